// File: rtl/plic.sv
// Platform-level interrupt controller: per-source gateways, priority/enable/threshold
// registers, claim/complete handshake and a registered external interrupt request.
module plic #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_SRC  = 8,
  parameter int unsigned PRIO_W   = 3,
  parameter int unsigned MEM_SIZE = 256,
  localparam int unsigned AW      = $clog2(MEM_SIZE)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_SRC-1:0] i_src,
  input  logic               i_re,
  input  logic               i_we,
  input  logic [AW-1:0]      i_addr,
  input  logic [XLEN-1:0]    i_wdata,
  output logic [XLEN-1:0]    o_rdata,
  output logic               o_meip
);

  localparam int unsigned WW  = AW - 2;
  localparam int unsigned IDW = $clog2(NUM_SRC + 1);

  localparam logic [WW-1:0] WA_PEND  = WW'(32'h80 >> 2);
  localparam logic [WW-1:0] WA_EN    = WW'(32'h84 >> 2);
  localparam logic [WW-1:0] WA_THR   = WW'(32'h88 >> 2);
  localparam logic [WW-1:0] WA_CLAIM = WW'(32'h8C >> 2);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    CLAIMED
  } gw_state_t;

  gw_state_t         gw_q [1:NUM_SRC];
  gw_state_t         gw_d [1:NUM_SRC];
  logic [PRIO_W-1:0] prio [1:NUM_SRC];
  logic [NUM_SRC:1]  en;
  logic [PRIO_W-1:0] thr;
  logic [NUM_SRC:1]  pend;
  logic [NUM_SRC:1]  elig;
  logic [IDW-1:0]    best_id;
  logic [PRIO_W-1:0] best_prio;
  logic [WW-1:0]     waddr;
  logic              claim_fire;
  logic              complete_fire;
  logic              unused_addr_lsb;

  assign waddr           = i_addr[AW-1:2];
  assign unused_addr_lsb = ^i_addr[1:0];
  assign claim_fire      = i_re && (waddr == WA_CLAIM);
  assign complete_fire   = i_we && (waddr == WA_CLAIM);

  always_comb begin
    pend = '0;
    elig = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      pend[k] = (gw_q[k] == PENDING);
      elig[k] = pend[k] && en[k] && (prio[k] > thr);
    end
  end

  // Strict '>' keeps the first (lowest-ID) source among equal priorities.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      if (elig[k] && (prio[k] > best_prio)) begin
        best_id   = IDW'(k);
        best_prio = prio[k];
      end
    end
  end

  always_comb begin
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      gw_d[k] = gw_q[k];
      case (gw_q[k])
        IDLE:    if (i_src[k-1]) gw_d[k] = PENDING;
        PENDING: if (claim_fire && (best_id == IDW'(k))) gw_d[k] = CLAIMED;
        CLAIMED: if (complete_fire && (i_wdata == XLEN'(k))) gw_d[k] = IDLE;
        default: gw_d[k] = IDLE;
      endcase
    end
  end

  always_comb begin
    o_rdata = '0;
    if (i_re) begin
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
        if (waddr == WW'(k)) o_rdata[PRIO_W-1:0] = prio[k];
      end
      case (waddr)
        WA_PEND:  o_rdata[NUM_SRC:1] = pend;
        WA_EN:    o_rdata[NUM_SRC:1] = en;
        WA_THR:   o_rdata[PRIO_W-1:0] = thr;
        WA_CLAIM: o_rdata[IDW-1:0] = best_id;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
        prio[k] <= '0;
        gw_q[k] <= IDLE;
      end
      en     <= '0;
      thr    <= '0;
      o_meip <= 1'b0;
    end else begin
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
        gw_q[k] <= gw_d[k];
        if (i_we && (waddr == WW'(k))) prio[k] <= i_wdata[PRIO_W-1:0];
      end
      if (i_we && (waddr == WA_EN))  en  <= i_wdata[NUM_SRC:1];
      if (i_we && (waddr == WA_THR)) thr <= i_wdata[PRIO_W-1:0];
      o_meip <= |elig;
    end
  end

endmodule

// File: tb/tb_plic.sv
// Scoreboard bench for plic: expectations are queued as stimulus is driven and
// compared on the falling clock edge against o_rdata / o_meip.
module tb_plic;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [7:0]  i_src = '0;
  logic        i_re = 1'b0;
  logic        i_we = 1'b0;
  logic [7:0]  i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic [31:0] o_rdata;
  logic        o_meip;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    bit          is_meip;
  } sb_t;

  sb_t sb [$];

  plic #(.XLEN(32), .NUM_SRC(8), .PRIO_W(3), .MEM_SIZE(256)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_src  (i_src),
    .i_re   (i_re),
    .i_we   (i_we),
    .i_addr (i_addr),
    .i_wdata(i_wdata),
    .o_rdata(o_rdata),
    .o_meip (o_meip)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge i_clk) begin
    while (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      if (e.is_meip) chk(e.tag, {31'b0, o_meip}, e.exp);
      else           chk(e.tag, o_rdata, e.exp);
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic exp_meip(input string tag, input logic v);
    sb.push_back('{tag: tag, exp: {31'b0, v}, is_meip: 1'b1});
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    i_we = 1'b1; i_addr = a; i_wdata = d;
    step();
    i_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    i_re = 1'b1; i_addr = a;
    sb.push_back('{tag: tag, exp: exp, is_meip: 1'b0});
    step();
    i_re = 1'b0;
  endtask

  task automatic pulse_src(input logic [7:0] s);
    i_src = s;
    step();
    i_src = '0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b0;
    step(); step();
    i_rst = 1'b1;
    exp_meip("rst_meip", 1'b0);
    rd("rst_prio3", 8'h0C, 32'h0);
    rd("rst_en", 8'h84, 32'h0);
    rd("rst_thr", 8'h88, 32'h0);
    rd("rst_pend", 8'h80, 32'h0);

    // Basic latency: source 3
    wr(8'h0C, 32'd2);
    wr(8'h84, 32'h08);
    i_src = 8'h04;
    exp_meip("lat_meip_n", 1'b0);
    step();
    exp_meip("lat_meip_n1", 1'b0);
    rd("lat_pend_n1", 8'h80, 32'h08);
    exp_meip("lat_meip_n2", 1'b1);
    rd("claim3", 8'h8C, 32'd3);
    exp_meip("meip_after_claim", 1'b1);
    rd("pend_after_claim", 8'h80, 32'h0);
    exp_meip("meip_two_after", 1'b0);
    step();
    rd("claimed_ignores_src", 8'h80, 32'h0);
    wr(8'h8C, 32'd7);
    rd("complete_idle_7", 8'h80, 32'h0);
    wr(8'h8C, 32'd3);
    step();
    rd("repend3", 8'h80, 32'h08);
    i_src = '0;
    rd("reclaim3", 8'h8C, 32'd3);
    wr(8'h8C, 32'd3);

    // Tie-break between equal priorities
    wr(8'h08, 32'd4);
    wr(8'h14, 32'd4);
    wr(8'h84, 32'h24);
    pulse_src(8'h12);
    rd("tie_pend", 8'h80, 32'h24);
    rd("tie_claim2", 8'h8C, 32'd2);
    rd("tie_claim5", 8'h8C, 32'd5);
    rd("tie_claim0", 8'h8C, 32'd0);
    rd("tie_pend_after", 8'h80, 32'h0);
    wr(8'h8C, 32'd2);
    pulse_src(8'h02);
    // Claim 2 and complete 5 on the same edge
    i_re = 1'b1; i_we = 1'b1; i_addr = 8'h8C; i_wdata = 32'd5;
    sb.push_back('{tag: "rw_claim2", exp: 32'd2, is_meip: 1'b0});
    step();
    i_re = 1'b0; i_we = 1'b0;
    pulse_src(8'h10);
    rd("rw_pend5_back", 8'h80, 32'h20);
    rd("rw_claim5", 8'h8C, 32'd5);
    wr(8'h8C, 32'd5);
    wr(8'h8C, 32'd2);

    // Threshold / enable gating
    wr(8'h10, 32'd3);
    wr(8'h88, 32'd3);
    wr(8'h84, 32'h10);
    pulse_src(8'h08);
    exp_meip("thr_meip_blocked", 1'b0);
    rd("thr_claim0", 8'h8C, 32'd0);
    rd("thr_pend", 8'h80, 32'h10);
    wr(8'h88, 32'd2);
    exp_meip("thr_meip_w", 1'b0);
    step();
    exp_meip("thr_meip_w1", 1'b1);
    wr(8'h84, 32'h0);
    exp_meip("dis_meip_w", 1'b1);
    step();
    exp_meip("dis_meip_w1", 1'b0);
    rd("dis_pend", 8'h80, 32'h10);
    wr(8'h84, 32'h10);
    rd("claim4", 8'h8C, 32'd4);
    wr(8'h8C, 32'd4);

    // Field masking and unmapped addresses
    wr(8'h84, 32'hFFFF_FFFF);
    rd("en_mask", 8'h84, 32'h0000_01FE);
    wr(8'h04, 32'hFFFF_FFFF);
    rd("prio1_mask", 8'h04, 32'h7);
    rd("addr00", 8'h00, 32'h0);
    rd("addrFC", 8'hFC, 32'h0);
    rd("prio9", 8'h24, 32'h0);
    wr(8'h80, 32'hFFFF_FFFF);
    rd("pend_ro", 8'h80, 32'h0);
    rd("thr_read", 8'h8A, 32'd2);

    // Reset with a claimed source
    wr(8'h18, 32'd5);
    pulse_src(8'h21);
    rd("pre_rst_claim1", 8'h8C, 32'd1);
    i_rst = 1'b0;
    step();
    i_rst = 1'b1;
    exp_meip("post_rst_meip", 1'b0);
    rd("post_rst_prio1", 8'h04, 32'h0);
    rd("post_rst_en", 8'h84, 32'h0);
    rd("post_rst_thr", 8'h88, 32'h0);
    rd("post_rst_pend", 8'h80, 32'h0);
    wr(8'h04, 32'd1);
    wr(8'h84, 32'h02);
    pulse_src(8'h01);
    rd("repend1", 8'h80, 32'h02);
    exp_meip("repend1_meip", 1'b1);
    rd("reclaim1", 8'h8C, 32'd1);

    step();
    chk("sb_drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
